// File: rtl/tl_pkg.sv
// Shared TileLink-UL constants and per-beat field widths for the DMA master mux.
package tl_pkg;

    localparam logic [2:0] OP_PUT_FULL_DATA    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL_DATA = 3'd1;
    localparam logic [2:0] OP_GET              = 3'd4;
    localparam logic [2:0] OP_ACCESS_ACK       = 3'd0;
    localparam logic [2:0] OP_ACCESS_ACK_DATA  = 3'd1;

    localparam int TL_OPW  = 3;
    localparam int TL_A_PW = 3;
    localparam int TL_D_PW = 2;
    localparam int TL_SZW  = 4;
    localparam int TL_AW   = 32;
    localparam int TL_DW   = 32;
    localparam int TL_MW   = 4;

    // Width of a channel index; a single channel still needs one bit to carry it.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tl_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins, wrapping.
module tl_rr_arbiter
    import tl_pkg::*;
#(
    parameter int N = 1,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        // Two passes: upper segment from the pointer first, then the wrapped lower part.
        for (int i = 0; i < N; i++) begin
            if (!any_o && req_i[i] && (i >= int'(ptr_i))) begin
                gnt_o[i] = 1'b1;
                idx_o    = IW'(i);
                any_o    = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any_o && req_i[i] && (i < int'(ptr_i))) begin
                gnt_o[i] = 1'b1;
                idx_o    = IW'(i);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tl_dma_master_mux.sv
// Merges per-channel TL-UL masters onto one master port: registered round-robin A path,
// source-routed zero-latency D path, per-channel outstanding-request limit.
module tl_dma_master_mux
    import tl_pkg::*;
#(
    parameter int NoC      = 1,
    parameter int TL_RS    = 4,
    parameter int MAX_OUTS = 2
) (
    input  logic                      dma_clock_i,
    input  logic                      dma_reset_i,
    input  logic [TL_OPW*NoC-1:0]     sa_opcode,
    input  logic [TL_A_PW*NoC-1:0]    sa_param,
    input  logic [TL_SZW*NoC-1:0]     sa_size,
    input  logic [TL_RS*NoC-1:0]      sa_source,
    input  logic [TL_AW*NoC-1:0]      sa_address,
    input  logic [TL_MW*NoC-1:0]      sa_mask,
    input  logic [TL_DW*NoC-1:0]      sa_data,
    input  logic [NoC-1:0]            sa_corrupt,
    input  logic [NoC-1:0]            sa_valid,
    output logic [NoC-1:0]            sa_ready,
    output logic [TL_OPW*NoC-1:0]     sd_opcode,
    output logic [TL_D_PW*NoC-1:0]    sd_param,
    output logic [TL_SZW*NoC-1:0]     sd_size,
    output logic [TL_RS*NoC-1:0]      sd_source,
    output logic [NoC-1:0]            sd_denied,
    output logic [TL_DW*NoC-1:0]      sd_data,
    output logic [NoC-1:0]            sd_corrupt,
    output logic [NoC-1:0]            sd_valid,
    input  logic [NoC-1:0]            sd_ready,
    output logic [TL_OPW-1:0]         m_a_opcode,
    output logic [TL_A_PW-1:0]        m_a_param,
    output logic [TL_SZW-1:0]         m_a_size,
    output logic [TL_RS-1:0]          m_a_source,
    output logic [TL_AW-1:0]          m_a_address,
    output logic [TL_MW-1:0]          m_a_mask,
    output logic [TL_DW-1:0]          m_a_data,
    output logic                      m_a_corrupt,
    output logic                      m_a_valid,
    input  logic                      m_a_ready,
    input  logic [TL_OPW-1:0]         m_d_opcode,
    input  logic [TL_D_PW-1:0]        m_d_param,
    input  logic [TL_SZW-1:0]         m_d_size,
    input  logic [TL_RS-1:0]          m_d_source,
    input  logic                      m_d_denied,
    input  logic [TL_DW-1:0]          m_d_data,
    input  logic                      m_d_corrupt,
    input  logic                      m_d_valid,
    output logic                      m_d_ready,
    output logic                      stray_d_o
);

    localparam int IW = idx_w(NoC);
    localparam int CW = $clog2(MAX_OUTS + 1);

    // Handshakes: a beat moves on any edge where valid & ready; valid never waits on ready.
    logic                     a_valid_q, a_valid_d;
    logic [TL_OPW-1:0]        a_opcode_q, a_opcode_d;
    logic [TL_A_PW-1:0]       a_param_q, a_param_d;
    logic [TL_SZW-1:0]        a_size_q, a_size_d;
    logic [TL_RS-1:0]         a_source_q, a_source_d;
    logic [TL_AW-1:0]         a_address_q, a_address_d;
    logic [TL_MW-1:0]         a_mask_q, a_mask_d;
    logic [TL_DW-1:0]         a_data_q, a_data_d;
    logic                     a_corrupt_q, a_corrupt_d;
    logic [IW-1:0]            ptr_q, ptr_d;
    logic [NoC-1:0][CW-1:0]   outs_q, outs_d;
    logic                     stray_q, stray_d;

    logic [NoC-1:0] eligible, gnt;
    logic [IW-1:0]  win_idx, d_idx;
    logic           any_elig, load_en, a_hs, d_hs, d_in_range, d_ready_sel;
    logic [CW-1:0]  outs_sel;
    logic           unused_src;

    assign unused_src = ^sa_source;

    always_comb begin
        for (int i = 0; i < NoC; i++) begin
            eligible[i] = sa_valid[i] & (outs_q[i] < CW'(MAX_OUTS));
        end
    end

    tl_rr_arbiter #(.N(NoC)) u_arb (
        .req_i (eligible),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (win_idx),
        .any_o (any_elig)
    );

    assign load_en  = ~a_valid_q | m_a_ready;
    assign a_hs     = load_en & any_elig;
    assign sa_ready = load_en ? gnt : '0;

    // Any source beyond the channel count (including set upper bits) is unroutable.
    assign d_in_range = ({1'b0, m_d_source} < (TL_RS + 1)'(NoC));
    assign d_idx      = IW'(m_d_source);

    always_comb begin
        sd_valid    = '0;
        d_ready_sel = 1'b0;
        outs_sel    = '0;
        for (int i = 0; i < NoC; i++) begin
            if (d_idx == IW'(i)) begin
                sd_valid[i] = m_d_valid & d_in_range;
                d_ready_sel = sd_ready[i];
                outs_sel    = outs_q[i];
            end
        end
    end

    assign m_d_ready = d_in_range ? d_ready_sel : 1'b1;
    assign d_hs      = m_d_valid & m_d_ready;

    assign sd_opcode  = {NoC{m_d_opcode}};
    assign sd_param   = {NoC{m_d_param}};
    assign sd_size    = {NoC{m_d_size}};
    assign sd_source  = '0;
    assign sd_denied  = {NoC{m_d_denied}};
    assign sd_data    = {NoC{m_d_data}};
    assign sd_corrupt = {NoC{m_d_corrupt}};

    always_comb begin
        a_valid_d   = a_valid_q;
        a_opcode_d  = a_opcode_q;
        a_param_d   = a_param_q;
        a_size_d    = a_size_q;
        a_source_d  = a_source_q;
        a_address_d = a_address_q;
        a_mask_d    = a_mask_q;
        a_data_d    = a_data_q;
        a_corrupt_d = a_corrupt_q;
        ptr_d       = ptr_q;
        if (a_hs) begin
            a_valid_d = 1'b1;
            ptr_d     = (win_idx == IW'(NoC - 1)) ? '0 : win_idx + 1'b1;
            for (int i = 0; i < NoC; i++) begin
                if (gnt[i]) begin
                    a_opcode_d  = sa_opcode[i*TL_OPW +: TL_OPW];
                    a_param_d   = sa_param[i*TL_A_PW +: TL_A_PW];
                    a_size_d    = sa_size[i*TL_SZW +: TL_SZW];
                    a_address_d = sa_address[i*TL_AW +: TL_AW];
                    a_mask_d    = sa_mask[i*TL_MW +: TL_MW];
                    a_data_d    = sa_data[i*TL_DW +: TL_DW];
                    a_corrupt_d = sa_corrupt[i];
                end
            end
            a_source_d = TL_RS'(win_idx);
        end else if (load_en) begin
            a_valid_d = 1'b0;
        end

        // Simultaneous issue and completion on a channel cancel; completion at zero saturates.
        for (int i = 0; i < NoC; i++) begin
            outs_d[i] = outs_q[i];
            if (a_hs && gnt[i] && !(d_hs && sd_valid[i])) begin
                outs_d[i] = outs_q[i] + 1'b1;
            end else if (d_hs && sd_valid[i] && !(a_hs && gnt[i]) && (outs_q[i] != '0)) begin
                outs_d[i] = outs_q[i] - 1'b1;
            end
        end

        stray_d = d_hs & (~d_in_range | (outs_sel == '0));
    end

    always_ff @(posedge dma_clock_i or posedge dma_reset_i) begin
        if (dma_reset_i) begin
            a_valid_q   <= 1'b0;
            a_opcode_q  <= '0;
            a_param_q   <= '0;
            a_size_q    <= '0;
            a_source_q  <= '0;
            a_address_q <= '0;
            a_mask_q    <= '0;
            a_data_q    <= '0;
            a_corrupt_q <= 1'b0;
            ptr_q       <= '0;
            outs_q      <= '0;
            stray_q     <= 1'b0;
        end else begin
            a_valid_q   <= a_valid_d;
            a_opcode_q  <= a_opcode_d;
            a_param_q   <= a_param_d;
            a_size_q    <= a_size_d;
            a_source_q  <= a_source_d;
            a_address_q <= a_address_d;
            a_mask_q    <= a_mask_d;
            a_data_q    <= a_data_d;
            a_corrupt_q <= a_corrupt_d;
            ptr_q       <= ptr_d;
            outs_q      <= outs_d;
            stray_q     <= stray_d;
        end
    end

    assign m_a_valid   = a_valid_q;
    assign m_a_opcode  = a_opcode_q;
    assign m_a_param   = a_param_q;
    assign m_a_size    = a_size_q;
    assign m_a_source  = a_source_q;
    assign m_a_address = a_address_q;
    assign m_a_mask    = a_mask_q;
    assign m_a_data    = a_data_q;
    assign m_a_corrupt = a_corrupt_q;
    assign stray_d_o   = stray_q;

endmodule

// File: tb/tb_tl_dma_master_mux.sv
// Bench for tl_dma_master_mux at two channels: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_tl_dma_master_mux;
  import tl_pkg::*;

  localparam int NOC = 2;
  localparam int RS  = 4;
  localparam int MO  = 2;

  logic clk = 1'b0;
  logic rst;
  logic [3*NOC-1:0]  sa_opcode, sa_param;
  logic [4*NOC-1:0]  sa_size, sa_mask;
  logic [RS*NOC-1:0] sa_source;
  logic [32*NOC-1:0] sa_address, sa_data;
  logic [NOC-1:0]    sa_corrupt, sa_valid, sa_ready;
  logic [3*NOC-1:0]  sd_opcode;
  logic [2*NOC-1:0]  sd_param;
  logic [4*NOC-1:0]  sd_size;
  logic [RS*NOC-1:0] sd_source;
  logic [NOC-1:0]    sd_denied, sd_corrupt, sd_valid, sd_ready;
  logic [32*NOC-1:0] sd_data;
  logic [2:0]  m_a_opcode, m_a_param;
  logic [3:0]  m_a_size, m_a_mask;
  logic [RS-1:0] m_a_source;
  logic [31:0] m_a_address, m_a_data;
  logic m_a_corrupt, m_a_valid, m_a_ready;
  logic [2:0]  m_d_opcode;
  logic [1:0]  m_d_param;
  logic [3:0]  m_d_size;
  logic [RS-1:0] m_d_source;
  logic m_d_denied, m_d_corrupt, m_d_valid, m_d_ready;
  logic [31:0] m_d_data;
  logic stray_d_o;

  int n_chk  = 0;
  int n_fail = 0;

  // Scoreboard of A beats the model says were loaded: {source, address, data}.
  logic [67:0] exp_q[$];

  tl_dma_master_mux #(.NoC(NOC), .TL_RS(RS), .MAX_OUTS(MO)) dut (
    .dma_clock_i(clk), .dma_reset_i(rst),
    .sa_opcode(sa_opcode), .sa_param(sa_param), .sa_size(sa_size), .sa_source(sa_source),
    .sa_address(sa_address), .sa_mask(sa_mask), .sa_data(sa_data), .sa_corrupt(sa_corrupt),
    .sa_valid(sa_valid), .sa_ready(sa_ready),
    .sd_opcode(sd_opcode), .sd_param(sd_param), .sd_size(sd_size), .sd_source(sd_source),
    .sd_denied(sd_denied), .sd_data(sd_data), .sd_corrupt(sd_corrupt), .sd_valid(sd_valid),
    .sd_ready(sd_ready),
    .m_a_opcode(m_a_opcode), .m_a_param(m_a_param), .m_a_size(m_a_size), .m_a_source(m_a_source),
    .m_a_address(m_a_address), .m_a_mask(m_a_mask), .m_a_data(m_a_data), .m_a_corrupt(m_a_corrupt),
    .m_a_valid(m_a_valid), .m_a_ready(m_a_ready),
    .m_d_opcode(m_d_opcode), .m_d_param(m_d_param), .m_d_size(m_d_size), .m_d_source(m_d_source),
    .m_d_denied(m_d_denied), .m_d_data(m_d_data), .m_d_corrupt(m_d_corrupt), .m_d_valid(m_d_valid),
    .m_d_ready(m_d_ready), .stray_d_o(stray_d_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  mo_outs[NOC];
  int  mo_ptr;
  bit  mo_av;
  bit  mo_stray;
  logic [2:0]  mo_op, mo_par;
  logic [3:0]  mo_sz, mo_src, mo_msk;
  logic [31:0] mo_adr, mo_dat;
  logic        mo_cor;

  int  win, inc_ch, dec_ch, src_i;
  bit  load_en, in_rng, exp_mdr, d_hs;
  logic [67:0] sb_front;

  always @(negedge clk) begin
    if (rst) begin
      foreach (mo_outs[k]) mo_outs[k] = 0;
      mo_ptr = 0; mo_av = 0; mo_stray = 0;
      exp_q.delete();
      chk("rst_m_a_valid", 128'(m_a_valid), 128'(0));
      chk("rst_stray", 128'(stray_d_o), 128'(0));
    end else begin
      // Expected A-side outputs: a free output slot goes to the first ready-to-issue
      // channel scanning from the pointer.
      load_en = !mo_av || m_a_ready;
      win = -1;
      for (int k = 0; k < NOC; k++) begin
        int c;
        c = (mo_ptr + k) % NOC;
        if (win < 0 && sa_valid[c] && mo_outs[c] < MO) win = c;
      end
      chk("sa_ready", 128'(sa_ready), (load_en && win >= 0) ? (128'(1) << win) : 128'(0));
      chk("m_a_valid", 128'(m_a_valid), 128'(mo_av));
      if (mo_av) begin
        chk("m_a_hdr", 128'({m_a_opcode, m_a_param, m_a_size, m_a_source, m_a_mask, m_a_corrupt}),
            128'({mo_op, mo_par, mo_sz, mo_src, mo_msk, mo_cor}));
        chk("m_a_addr", 128'(m_a_address), 128'(mo_adr));
        chk("m_a_data", 128'(m_a_data), 128'(mo_dat));
      end
      chk("stray", 128'(stray_d_o), 128'(mo_stray));

      if (m_a_valid === 1'b1 && m_a_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 128'(1), 128'(0));
        end else begin
          sb_front = exp_q.pop_front();
          chk("sb_beat", 128'({m_a_source, m_a_address, m_a_data}), 128'(sb_front));
        end
      end

      // Expected D-side outputs: source selects the channel, anything else is sunk.
      src_i  = int'(m_d_source);
      in_rng = src_i < NOC;
      exp_mdr = in_rng ? sd_ready[src_i] : 1'b1;
      chk("sd_valid", 128'(sd_valid), (in_rng && m_d_valid) ? (128'(1) << src_i) : 128'(0));
      chk("m_d_ready", 128'(m_d_ready), 128'(exp_mdr));
      chk("sd_fanout", 128'({sd_data, sd_opcode, sd_source}),
          128'({m_d_data, m_d_data, m_d_opcode, m_d_opcode, 8'h00}));

      // Advance the model by one clock.
      d_hs     = m_d_valid && exp_mdr;
      mo_stray = d_hs && (!in_rng || mo_outs[src_i] == 0);
      inc_ch   = (load_en && win >= 0) ? win : -1;
      dec_ch   = (d_hs && in_rng) ? src_i : -1;
      if (!(inc_ch >= 0 && inc_ch == dec_ch)) begin
        if (inc_ch >= 0) mo_outs[inc_ch]++;
        if (dec_ch >= 0 && mo_outs[dec_ch] > 0) mo_outs[dec_ch]--;
      end
      if (load_en) begin
        if (win >= 0) begin
          mo_av  = 1;
          mo_op  = 3'(sa_opcode >> (3 * win));
          mo_par = 3'(sa_param >> (3 * win));
          mo_sz  = 4'(sa_size >> (4 * win));
          mo_msk = 4'(sa_mask >> (4 * win));
          mo_adr = 32'(sa_address >> (32 * win));
          mo_dat = 32'(sa_data >> (32 * win));
          mo_cor = sa_corrupt[win];
          mo_src = 4'(win);
          mo_ptr = (win + 1) % NOC;
          exp_q.push_back({mo_src, mo_adr, mo_dat});
        end else begin
          mo_av = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int ch, input logic [2:0] op, input logic [31:0] adr, input logic [31:0] dat);
    sa_opcode[ch*3 +: 3]   = op;
    sa_param[ch*3 +: 3]    = 3'd0;
    sa_size[ch*4 +: 4]     = 4'd2;
    sa_source[ch*RS +: RS] = 4'($urandom_range(0, 15));
    sa_address[ch*32 +: 32] = adr;
    sa_mask[ch*4 +: 4]     = 4'hf;
    sa_data[ch*32 +: 32]   = dat;
    sa_corrupt[ch]         = 1'b0;
  endtask

  task automatic idle_inputs();
    sa_opcode = '0; sa_param = '0; sa_size = '0; sa_source = '0;
    sa_address = '0; sa_mask = '0; sa_data = '0; sa_corrupt = '0; sa_valid = '0;
    sd_ready = '0; m_a_ready = 1'b0;
    m_d_opcode = '0; m_d_param = '0; m_d_size = '0; m_d_source = '0;
    m_d_denied = 1'b0; m_d_data = '0; m_d_corrupt = 1'b0; m_d_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic rand_cycle();
    rst = ($urandom_range(0, 299) == 0);
    for (int c = 0; c < NOC; c++) begin
      set_a(c, ($urandom_range(0, 1) != 0) ? OP_GET : OP_PUT_FULL_DATA, $urandom, $urandom);
      sa_param[c*3 +: 3] = 3'($urandom_range(0, 7));
      sa_size[c*4 +: 4]  = 4'($urandom_range(0, 15));
      sa_mask[c*4 +: 4]  = 4'($urandom_range(0, 15));
      sa_corrupt[c]      = ($urandom_range(0, 7) == 0);
    end
    sa_valid    = NOC'($urandom_range(0, 3));
    sd_ready    = NOC'($urandom_range(0, 3));
    m_a_ready   = ($urandom_range(0, 3) != 0);
    m_d_valid   = ($urandom_range(0, 2) == 0);
    m_d_source  = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(2, 15));
    m_d_opcode  = ($urandom_range(0, 1) != 0) ? OP_ACCESS_ACK_DATA : OP_ACCESS_ACK;
    m_d_data    = $urandom;
    m_d_param   = 2'($urandom_range(0, 3));
    m_d_size    = 4'($urandom_range(0, 15));
    m_d_denied  = ($urandom_range(0, 7) == 0);
    m_d_corrupt = ($urandom_range(0, 7) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    idle_inputs();
    do_reset();

    // Same-cycle requests: ch0 first, ch1 next; the pointer brings ch0 back first.
    m_a_ready = 1'b1; sd_ready = 2'b11;
    set_a(0, OP_GET, 32'h1000, 32'h0);
    set_a(1, OP_PUT_FULL_DATA, 32'h2000, 32'hcafe0001);
    sa_valid = 2'b11;
    #1 chk("t1_first_grant", 128'(sa_ready), 128'(2'b01));
    step();
    chk("t1_src0", 128'(m_a_source), 128'(0));
    chk("t1_addr0", 128'(m_a_address), 128'(32'h1000));
    chk("t1_op0", 128'(m_a_opcode), 128'(3'd4));
    sa_valid = 2'b10;
    step();
    chk("t1_src1", 128'(m_a_source), 128'(1));
    chk("t1_addr1", 128'(m_a_address), 128'(32'h2000));
    chk("t1_op1", 128'(m_a_opcode), 128'(3'd0));
    sa_valid = 2'b11;
    step();
    chk("t1_rep_src0", 128'(m_a_source), 128'(0));
    sa_valid = 2'b10;
    step();
    chk("t1_rep_src1", 128'(m_a_source), 128'(1));

    // Outstanding limit on ch0, released by a returning D beat.
    sa_valid = 2'b01;
    #1 chk("t2_blocked", 128'(sa_ready), 128'(0));
    m_d_valid = 1'b1; m_d_source = 4'd0; m_d_opcode = OP_ACCESS_ACK_DATA; m_d_data = 32'hdeadbeef;
    #1;
    chk("t2_sd_valid", 128'(sd_valid), 128'(2'b01));
    chk("t2_sd_data", 128'(sd_data[31:0]), 128'(32'hdeadbeef));
    chk("t2_m_d_ready", 128'(m_d_ready), 128'(1));
    step();
    m_d_valid = 1'b0;
    #1 chk("t2_reopen", 128'(sa_ready), 128'(2'b01));
    step();
    chk("t2_issue", 128'({m_a_valid, m_a_source}), 128'({1'b1, 4'd0}));
    sa_valid = 2'b00;

    // Output stall holds the register and blocks every channel.
    do_reset();
    set_a(0, OP_GET, 32'h3000, 32'h0);
    sa_valid = 2'b01;
    step();
    set_a(1, OP_PUT_FULL_DATA, 32'h4000, 32'h12345678);
    sa_valid = 2'b11;
    repeat (5) begin
      #1;
      chk("t3_hold_valid", 128'(m_a_valid), 128'(1));
      chk("t3_hold_addr", 128'(m_a_address), 128'(32'h3000));
      chk("t3_hold_ready", 128'(sa_ready), 128'(0));
      step();
    end
    m_a_ready = 1'b1;
    #1 chk("t3_release_grant", 128'(sa_ready), 128'(2'b10));
    step();
    chk("t3_next_beat", 128'({m_a_source, m_a_address}), 128'({4'd1, 32'h4000}));
    sa_valid = 2'b00;

    // Unroutable D source is sunk and flagged a cycle later.
    do_reset();
    m_d_valid = 1'b1; m_d_source = 4'd5;
    #1;
    chk("t4_sink_ready", 128'(m_d_ready), 128'(1));
    chk("t4_no_route", 128'(sd_valid), 128'(0));
    step();
    m_d_valid = 1'b0;
    chk("t4_stray_pulse", 128'(stray_d_o), 128'(1));
    step();
    chk("t4_stray_clear", 128'(stray_d_o), 128'(0));

    // Issue and completion on ch1 in the same cycle leave its count at one.
    do_reset();
    m_a_ready = 1'b1; sd_ready = 2'b11;
    set_a(1, OP_GET, 32'h5000, 32'h0);
    sa_valid = 2'b10;
    step();
    m_d_valid = 1'b1; m_d_source = 4'd1;
    #1 chk("t5_grant", 128'(sa_ready), 128'(2'b10));
    step();
    m_d_valid = 1'b0;
    chk("t5_no_stray", 128'(stray_d_o), 128'(0));
    #1 chk("t5_still_one", 128'(sa_ready), 128'(2'b10));
    step();
    chk("t5_now_full", 128'(sa_ready), 128'(2'b00));
    sa_valid = 2'b00;

    // Asynchronous reset in the middle of a stall.
    do_reset();
    set_a(0, OP_GET, 32'h6000, 32'h0);
    sa_valid = 2'b01;
    step();
    sa_valid = 2'b00;
    chk("t6_pre_valid", 128'(m_a_valid), 128'(1));
    #2 rst = 1'b1;
    #1 chk("t6_async_drop", 128'(m_a_valid), 128'(0));
    step();
    step();
    rst = 1'b0; m_a_ready = 1'b1; sd_ready = 2'b11;
    set_a(1, OP_GET, 32'h7000, 32'h0);
    sa_valid = 2'b10;
    step();
    chk("t6_first_after", 128'({m_a_valid, m_a_source, m_a_address}), 128'({1'b1, 4'd1, 32'h7000}));
    sa_valid = 2'b00;
    m_d_valid = 1'b1; m_d_source = 4'd0;
    step();
    m_d_valid = 1'b0;
    chk("t6_stale_stray", 128'(stray_d_o), 128'(1));

    // Randomized traffic; the model checks every cycle.
    repeat (3000) begin
      rand_cycle();
      step();
    end
    rst = 1'b0;
    idle_inputs();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tl_dma_master_mux.md
Name: tl_dma_master_mux

Overview:
- Downstream stage of the multi-channel DMA controller. Merges the NoC per-channel TileLink-UL master ports (sa_*/sd_*) into a single TL-UL master port toward the system interconnect.
- Arbitrates the A channel round-robin and tags each request's source with its channel index.
- Routes D-channel responses back to the owning channel by source.
- Limits outstanding requests per channel.

Parameters:
- NoC, 1, number of DMA channels merged (1..16).
- TL_RS, 4, TileLink source width on both sides; requires TL_RS >= max(1, $clog2(NoC)).
- MAX_OUTS, 2, maximum outstanding A requests per channel (1..7).

Ports:
- dma_clock_i  in  1  clock
- dma_reset_i  in  1  asynchronous active-high reset
- sa_opcode  in  3*NoC  per-channel A opcode
- sa_param  in  3*NoC  per-channel A param
- sa_size  in  4*NoC  per-channel A size
- sa_source  in  TL_RS*NoC  per-channel A source (ignored)
- sa_address  in  32*NoC  per-channel A address
- sa_mask  in  4*NoC  per-channel A mask
- sa_data  in  32*NoC  per-channel A data
- sa_corrupt  in  NoC  per-channel A corrupt
- sa_valid  in  NoC  per-channel A valid
- sa_ready  out  NoC  per-channel A ready
- sd_opcode  out  3*NoC  routed D opcode
- sd_param  out  2*NoC  routed D param
- sd_size  out  4*NoC  routed D size
- sd_source  out  TL_RS*NoC  routed D source, always 0
- sd_denied  out  NoC  routed D denied
- sd_data  out  32*NoC  routed D data
- sd_corrupt  out  NoC  routed D corrupt
- sd_valid  out  NoC  routed D valid
- sd_ready  in  NoC  per-channel D ready
- m_a_opcode/m_a_param/m_a_size/m_a_source/m_a_address/m_a_mask/m_a_data/m_a_corrupt  out  3/3/4/TL_RS/32/4/32/1  registered master A fields
- m_a_valid  out  1  master A valid
- m_a_ready  in  1  master A ready
- m_d_opcode/m_d_param/m_d_size/m_d_source/m_d_denied/m_d_data/m_d_corrupt  in  3/2/4/TL_RS/1/32/1  master D fields
- m_d_valid  in  1  master D valid
- m_d_ready  out  1  master D ready
- stray_d_o  out  1  one-cycle pulse: unroutable or unexpected D beat

Behaviour:
- Reset (async, active-high):
  - m_a_valid=0; all m_a_* fields 0.
  - Outstanding counters 0; round-robin pointer 0; stray_d_o=0.
- A path, one output register:
  - load_en = ~m_a_valid | m_a_ready.
  - Channel i is eligible when sa_valid[i] & (outs[i] < MAX_OUTS).
  - Winner is the first eligible channel at or after the pointer (wrapping).
  - sa_ready[i] = load_en & (winner==i), combinational; at most one bit is set per cycle.
  - On a handshake, the register captures the channel fields, m_a_source = i zero-extended, and m_a_valid=1. The pointer moves to winner+1 mod NoC.
  - If load_en and no channel is eligible: m_a_valid <= 0 and the pointer holds.
  - Latency: sa handshake in cycle N gives m_a_valid in N+1.
  - Back-to-back issue at one request per cycle is sustained while m_a_ready=1.
  - Stalled output (m_a_valid & ~m_a_ready): register holds, all sa_ready=0.
- D path, combinational passthrough, zero latency:
  - idx = m_d_source[clog2 bits]; the upper source bits must be 0.
  - If idx < NoC and the upper bits are 0:
    - sd_valid[idx] = m_d_valid; m_d_ready = sd_ready[idx].
    - The fields fan out to all channels; only valid is gated.
  - Otherwise, or if outs[idx]==0: the beat is still sunk or routed as below, and stray_d_o pulses (registered, 1 cycle later).
    - Out-of-range beats are sunk with m_d_ready=1; sd_valid stays all 0.
    - In-range beats with outs[idx]==0 are routed normally and the counter does not underflow.
- Outstanding counters, width $clog2(MAX_OUTS+1):
  - Increment on sa handshake; decrement on m_d_valid & m_d_ready for that channel.
  - Both in the same cycle on the same channel: the counter is unchanged.
  - A decrement at 0 saturates at 0.
- Reset mid-transaction:
  - Drops m_a_valid immediately (async) and clears the counters.
  - Responses arriving after reset for pre-reset requests are routed per the rules above (stray_d_o if the counter is 0).
- NoC=1: the pointer is constant 0 and the arbiter degenerates to a pass-through with the register.

Decomposition:
- Shared package tl_pkg holds:
  - Opcode constants: PutFullData=0, PutPartialData=1, Get=4, AccessAck=0, AccessAckData=1.
  - The per-beat A/D field widths.
- One sub-module, tl_rr_arbiter #(N): request vector and pointer in, one-hot grant and encoded index out. Purely combinational.
- The pointer register stays in the parent.

Test Plan:
- NoC=2: ch0 Get 0x1000 and ch1 PutFull 0x2000 valid in the same cycle, m_a_ready=1 -> ch0 issues first with m_a_source=0, ch1 next cycle with m_a_source=1; the pointer alternates on repeat.
- MAX_OUTS=2, ch0 issues 2 Gets, no D returned -> the third request sees sa_ready[0]=0. Then D AccessAckData with source 0, data 0xDEADBEEF -> sd_valid[0]=1 with that data, and sa_ready[0] reasserts the next cycle.
- m_a_ready held low 5 cycles with m_a_valid=1 -> m_a_* stable and all sa_ready=0 throughout. Release -> the beat transfers and the next winner loads the same cycle.
- D with m_d_source=5 at NoC=2 -> m_d_ready=1, sd_valid=00, stray_d_o=1 one cycle later.
- Same-cycle sa handshake and D completion on ch1 with outs[1]=1 -> outs[1] stays 1.
- Assert dma_reset_i asynchronously mid-stall -> m_a_valid=0 without a clock edge. After release, the first request from ch1 issues in one cycle.
